// File: rtl/subpel_sad_acc.sv
`default_nettype none
// ============================================================================
// Module   : subpel_sad_acc
// Brief    : Per-candidate SAD accumulation over a block of lines followed by
//            a sequential minimum search. Optional SUBPEL_SAD_DUMP_EN exposes
//            all candidate SADs on sad_all.
// Revision : 1.0 - initial release
// ============================================================================
module subpel_sad_acc #(
    parameter  int NPIX   = 8,
    parameter  int NCAND  = 15,
    parameter  int BLK_H  = 8,
    parameter  int PIX_W  = 8,
    localparam int ACC_W  = PIX_W + $clog2((NPIX - 1) * BLK_H),
    localparam int IDX_W  = (NCAND > 1) ? $clog2(NCAND) : 1,
    localparam int LINE_W = NCAND * (NPIX - 1) * PIX_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [LINE_W-1:0] diff_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [IDX_W-1:0]  best_idx,
    output logic [ACC_W-1:0]  best_sad,
`ifdef SUBPEL_SAD_DUMP_EN
    output logic [NCAND*ACC_W-1:0] sad_all,
`endif
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int CNT_W = (BLK_H > 1) ? $clog2(BLK_H) : 1;
    localparam int NDIFF = NPIX - 1;

    typedef enum logic [1:0] {
        ACC    = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ACC_W-1:0]   r_acc [NCAND];
    logic [ACC_W-1:0]   w_line_sum [NCAND];
    logic [CNT_W-1:0]   r_line_cnt;
    logic [IDX_W-1:0]   r_scan_idx;
    logic [IDX_W-1:0]   r_best_idx;
    logic [ACC_W-1:0]   r_best_sad;
    logic [ACC_W-1:0]   w_scan_sad;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_last_line;
    logic               w_scan_last;

    assign w_accept    = in_valid & r_in_ready;
    assign w_last_line = (r_line_cnt == CNT_W'(BLK_H - 1));
    assign w_scan_last = (r_scan_idx == IDX_W'(NCAND - 1));
    assign w_scan_sad  = r_acc[r_scan_idx];

    always_comb begin
        for (int c = 0; c < NCAND; c++) begin
            w_line_sum[c] = '0;
            for (int k = 0; k < NDIFF; k++) begin
                w_line_sum[c] = w_line_sum[c]
                              + ACC_W'(diff_in[(c*NDIFF + k)*PIX_W +: PIX_W]);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACC:     if (w_accept && w_last_line) w_state_nxt = SEARCH;
            SEARCH:  if (w_scan_last)             w_state_nxt = DONE;
            DONE:    if (out_ready)               w_state_nxt = ACC;
            default:                              w_state_nxt = ACC;
        endcase
    end

    // Handshake flags are registered so in_ready stays low until the first
    // edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ACC;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_line_cnt  <= '0;
            r_scan_idx  <= '0;
            r_best_idx  <= '0;
            r_best_sad  <= '0;
            for (int c = 0; c < NCAND; c++) r_acc[c] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_in_ready  <= (w_state_nxt == ACC);
            r_out_valid <= (w_state_nxt == DONE);

            if (w_accept) begin
                for (int c = 0; c < NCAND; c++) begin
                    r_acc[c] <= ((r_line_cnt == '0) ? '0 : r_acc[c]) + w_line_sum[c];
                end
                r_line_cnt <= w_last_line ? '0 : r_line_cnt + 1'b1;
            end

            // Strict less-than keeps the lower index on ties.
            if (r_state == SEARCH) begin
                if ((r_scan_idx == '0) || (w_scan_sad < r_best_sad)) begin
                    r_best_sad <= w_scan_sad;
                    r_best_idx <= r_scan_idx;
                end
                r_scan_idx <= w_scan_last ? '0 : r_scan_idx + 1'b1;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign best_idx  = r_best_idx;
    assign best_sad  = r_best_sad;

`ifdef SUBPEL_SAD_DUMP_EN
    for (genvar c = 0; c < NCAND; c++) begin : g_dump
        assign sad_all[c*ACC_W +: ACC_W] = r_acc[c];
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_subpel_sad_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_subpel_sad_acc
// Brief    : Randomized self-checking bench for subpel_sad_acc against a
//            block-level SAD/argmin reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subpel_sad_acc;

    localparam int NPIX   = 8;
    localparam int NCAND  = 15;
    localparam int BLK_H  = 8;
    localparam int PIX_W  = 8;
    localparam int ND     = NPIX - 1;
    localparam int ACC_W  = 14;
    localparam int IDX_W  = 4;
    localparam int LINE_W = NCAND * ND * PIX_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [LINE_W-1:0] diff_in = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [IDX_W-1:0]  best_idx;
    logic [ACC_W-1:0]  best_sad;
    logic              out_valid;
    logic              out_ready = 1'b0;
`ifdef SUBPEL_SAD_DUMP_EN
    logic [NCAND*ACC_W-1:0] sad_all;
`endif

    subpel_sad_acc #(
        .NPIX  (NPIX),
        .NCAND (NCAND),
        .BLK_H (BLK_H),
        .PIX_W (PIX_W)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .diff_in   (diff_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .best_idx  (best_idx),
        .best_sad  (best_sad),
`ifdef SUBPEL_SAD_DUMP_EN
        .sad_all   (sad_all),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [PIX_W-1:0] blk [BLK_H][NCAND][ND];
    longint exp_sad [NCAND];
    longint exp_idx;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Block-level reference: total per candidate, then lowest-index minimum.
    task automatic compute_model();
        for (int c = 0; c < NCAND; c++) begin
            exp_sad[c] = 0;
            for (int l = 0; l < BLK_H; l++)
                for (int k = 0; k < ND; k++)
                    exp_sad[c] += blk[l][c][k];
        end
        exp_idx = 0;
        for (int c = 1; c < NCAND; c++)
            if (exp_sad[c] < exp_sad[exp_idx]) exp_idx = c;
    endtask

    function automatic logic [LINE_W-1:0] pack_line(input int l);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int c = 0; c < NCAND; c++)
            for (int k = 0; k < ND; k++)
                v[(c*ND + k)*PIX_W +: PIX_W] = blk[l][c][k];
        return v;
    endfunction

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W/8; i++) v[i*8 +: 8] = 8'($urandom);
        return v;
    endfunction

    task automatic fill_const(input int val);
        for (int l = 0; l < BLK_H; l++)
            for (int c = 0; c < NCAND; c++)
                for (int k = 0; k < ND; k++)
                    blk[l][c][k] = PIX_W'(val);
    endtask

    task automatic fill_random();
        for (int c = 0; c < NCAND; c++) begin
            int maxc;
            maxc = $urandom_range(0, 255);
            for (int l = 0; l < BLK_H; l++)
                for (int k = 0; k < ND; k++)
                    blk[l][c][k] = PIX_W'($urandom_range(0, maxc));
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send_line(input int l);
        int w;
        diff_in  = pack_line(l);
        in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (w >= 200) chk("accept_timeout", 0, 1);
        @(negedge clk);
        in_valid = 1'b0;
        diff_in  = rand_line();
    endtask

    task automatic run_block(input bit gaps, input string name);
        int lat;
        compute_model();
        for (int l = 0; l < BLK_H; l++) begin
            send_line(l);
            if (gaps && l != BLK_H-1) @(negedge clk);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk({name, "_latency"}, lat, NCAND + 1);
        chk({name, "_idx"}, best_idx, exp_idx);
        chk({name, "_sad"}, best_sad, exp_sad[exp_idx]);
        chk({name, "_in_ready_low"}, in_ready, 0);
`ifdef SUBPEL_SAD_DUMP_EN
        for (int c = 0; c < NCAND; c++)
            chk({name, "_dump"}, sad_all[c*ACC_W +: ACC_W], exp_sad[c]);
`endif
    endtask

    task automatic finish_result(input int delay, input string name);
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            chk({name, "_hold_valid"}, out_valid, 1);
            chk({name, "_hold_sad"}, best_sad, exp_sad[exp_idx]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({name, "_post_valid"}, out_valid, 0);
        chk({name, "_post_ready"}, in_ready, 1);
    endtask

    task automatic do_reset(input string name);
        #2 rst_n = 1'b0;
        #1;
        chk({name, "_rst_in_ready"}, in_ready, 0);
        chk({name, "_rst_out_valid"}, out_valid, 0);
        chk({name, "_rst_idx"}, best_idx, 0);
        chk({name, "_rst_sad"}, best_sad, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, "_rel_in_ready_low"}, in_ready, 0);
        @(negedge clk);
        chk({name, "_rel_in_ready_high"}, in_ready, 1);
    endtask

    initial begin
        logic [IDX_W-1:0] hold_idx;
        logic [ACC_W-1:0] hold_sad;

        repeat (3) @(negedge clk);
        chk("init_in_ready", in_ready, 0);
        chk("init_out_valid", out_valid, 0);
        chk("init_sad", best_sad, 0);
        rst_n = 1'b1;
        #1;
        chk("init_rel_in_ready_low", in_ready, 0);
        @(negedge clk);
        chk("init_rel_in_ready_high", in_ready, 1);

        // All-zero block
        fill_const(0);
        run_block(1'b0, "zero");
        finish_result(0, "zero");

        // Candidate 9 is the only low-cost position
        fill_const(255);
        for (int l = 0; l < BLK_H; l++)
            for (int k = 0; k < ND; k++) blk[l][9][k] = 8'd1;
        run_block(1'b0, "cand9");
        chk("cand9_ref_idx", best_idx, 9);
        chk("cand9_ref_sad", best_sad, 56);
        finish_result(2, "cand9");

        // Tie between candidates 4 and 11 resolves to the lower index
        fill_const(1);
        for (int l = 0; l < BLK_H; l++)
            for (int k = 0; k < ND; k++) begin
                blk[l][4][k]  = 8'd0;
                blk[l][11][k] = 8'd0;
            end
        blk[0][4][0]  = 8'd10;
        blk[3][11][5] = 8'd10;
        run_block(1'b0, "tie");
        chk("tie_ref_idx", best_idx, 4);
        chk("tie_ref_sad", best_sad, 10);
        finish_result(0, "tie");

        // Consumer stall with upstream pushing lines that must be ignored
        fill_random();
        run_block(1'b0, "stall");
        hold_idx = best_idx;
        hold_sad = best_sad;
        for (int i = 0; i < 20; i++) begin
            diff_in  = rand_line();
            in_valid = 1'b1;
            @(negedge clk);
            chk("stall_valid", out_valid, 1);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_idx", best_idx, hold_idx);
            chk("stall_sad", best_sad, hold_sad);
        end
        in_valid = 1'b0;
        finish_result(0, "stall");
        fill_random();
        run_block(1'b0, "after_stall");
        finish_result(1, "after_stall");

        // Reset after five lines discards the partial block
        fill_random();
        for (int l = 0; l < 5; l++) send_line(l);
        do_reset("mid_blk");
        fill_random();
        run_block(1'b0, "post_mid_blk");
        finish_result(0, "post_mid_blk");

        // Reset during the search phase
        fill_random();
        for (int l = 0; l < BLK_H; l++) send_line(l);
        repeat (5) @(negedge clk);
        do_reset("mid_search");
        fill_random();
        run_block(1'b0, "post_search");
        finish_result(0, "post_search");

        // Gapped and gapless delivery of the same block
        fill_random();
        run_block(1'b1, "gapped");
        finish_result(0, "gapped");
        run_block(1'b0, "gapless");
        finish_result(0, "gapless");

        for (int b = 0; b < 6; b++) begin
            fill_random();
            run_block(1'($urandom_range(0, 1)), "rand");
            finish_result($urandom_range(0, 4), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/subpel_sad_acc.md
SUBPEL_SAD_ACC -- requirements
Module: subpel_sad_acc

Interface
REQ-001 SHALL have parameter NPIX, default 8: full pixels per input line; NPIX-1 diffs per candidate per line.
REQ-002 SHALL have parameter NCAND, default 15: candidate sub-pixel positions per line.
REQ-003 SHALL have parameter BLK_H, default 8: lines per block.
REQ-004 SHALL have parameter PIX_W, default 8: bits per diff.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port diff_in, input, NCAND*(NPIX-1)*PIX_W: absolute diffs; candidate c occupies slice c, diff k at bits k*PIX_W within slice.
REQ-008 SHALL have port in_valid, input, 1: diff_in line valid.
REQ-009 SHALL have port in_ready, output, 1: block accepts a line.
REQ-010 SHALL have port best_idx, output, clog2(NCAND): winning candidate index.
REQ-011 SHALL have port best_sad, output, ACC_W: winning SAD, ACC_W = PIX_W + clog2((NPIX-1)*BLK_H), 14 at defaults.
REQ-012 SHALL have port out_valid, output, 1: result valid.
REQ-013 SHALL have port out_ready, input, 1: consumer accepts result.

Function
REQ-014 SHALL implement FSM states ACC, SEARCH, DONE; reset enters ACC.
REQ-015 In ACC, in_ready SHALL be 1; all other states 0.
REQ-016 A line SHALL be accepted on a clk edge with in_valid=1 and in_ready=1; no acceptance otherwise, acc unchanged.
REQ-017 On acceptance, per candidate c: acc[c] <= (line_cnt==0 ? 0 : acc[c]) + sum of its NPIX-1 diffs, zero-extended to ACC_W, no saturation, no overflow possible.
REQ-018 line_cnt SHALL increment per acceptance; accepting line BLK_H-1 SHALL reset line_cnt to 0 and enter SEARCH next cycle.
REQ-019 SEARCH SHALL scan candidates 0..NCAND-1, one per cycle, taking exactly NCAND cycles, then enter DONE.
REQ-020 Scan: candidate 0 loads best unconditionally; candidate c replaces best only if acc[c] < best_sad (strict); ties keep lower index.
REQ-021 In DONE, out_valid SHALL be 1 and best_idx/best_sad stable until out_ready=1 handshake.
REQ-022 On handshake, SHALL return to ACC next cycle; out_valid 0 from that cycle.
REQ-023 Latency: last line acceptance to out_valid = NCAND+1 cycles (16 at defaults).
REQ-024 Lines offered while not in ACC SHALL be ignored (in_ready=0); upstream holds them.
REQ-025 out_ready outside DONE SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL asynchronously force: state ACC, line_cnt 0, all acc 0, best_idx 0, best_sad 0, out_valid 0, in_ready 0 while asserted.
REQ-027 Reset mid-block or mid-SEARCH SHALL discard partial results; first accepted line after release starts a new block.
REQ-028 Reset release synchronous to clk; in_ready rises on first clk edge after deassertion.

Configuration
REQ-029 Macro SUBPEL_SAD_DUMP_EN defined: SHALL add output sad_all, NCAND*ACC_W, acc[c] at slice c, stable and valid whenever out_valid=1.
REQ-030 Macro undefined: port sad_all SHALL be absent; all other behaviour identical.

Verification
REQ-031 All diffs 0 for 8 lines -> out_valid 16 cycles after last accept, best_idx 0, best_sad 0.
REQ-032 All diffs 255 except candidate 9 all 1, 8 lines -> best_idx 9, best_sad 56; others (dump) 14280.
REQ-033 Candidates 4 and 11 tie at 10, rest larger -> best_idx 4, best_sad 10.
REQ-034 out_ready held 0 for 20 cycles in DONE -> outputs stable, in_ready 0, in_valid lines not accepted; out_ready 1 -> ACC next cycle.
REQ-035 rst_n pulsed low after 5 lines and during SEARCH -> outputs reset immediately; fresh 8-line block gives correct result uncontaminated.
REQ-036 in_valid toggled every other cycle -> only valid lines summed; result equals gapless stream.
